conv_filter_scheduler: RTL

- Time-multiplexes one single-filter 3-stage convolution engine across NUM_FILTERS filters.
- Accepts one window via a valid/ready handshake and captures it.
- Issues it to the engine once per filter, each time with that filter's weights and bias.
- Collects the in-order engine results and presents all filter outputs as one packed vector with valid/ready.

---
 rtl/conv_filter_scheduler.sv | 254 +++++++++++++++++++++++++
 1 files changed

// File: rtl/conv_filter_scheduler.sv
// conv_filter_scheduler
//   Time-multiplexes one single-filter convolution engine across NUM_FILTERS
//   filters. A window is accepted over a valid/ready handshake and captured. It is
//   then issued to the engine once per filter, back to back, together with that
//   filter's weight and bias slices. The in-order engine results are collected
//   into a buffer and presented as one packed vector over valid/ready.
//
//   Optional build macro: CONV_SCHED_PERF_EN adds the perf_windows and
//   perf_stall counters and their output ports.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   window_in           packed K*K window of DATA_WIDTH pixels
//   win_valid/win_ready window handshake (ready only when idle and weights_valid)
//   weights             all filter weights, filter f in slice f
//   weights_valid       weights usable; gates window acceptance only
//   bias, bias_enable   per-filter bias slices and enable (enable captured on accept)
//   eng_window          captured window to the engine
//   eng_weights         weight slice of the filter being issued
//   eng_bias            bias slice of the filter being issued
//   eng_bias_enable     bias_enable captured at acceptance
//   eng_valid           engine window_valid / weights_valid
//   eng_out(_valid)     in-order engine results
//   conv_out            packed results, filter f at [(f+1)*OUTPUT_WIDTH-1 -: OUTPUT_WIDTH]
//   conv_valid/ready    result vector handshake
//   busy                scheduler not idle
//   err                 sticky: stray/excess engine result or drain timeout
//   perf_windows        (CONV_SCHED_PERF_EN) accepted window count
//   perf_stall          (CONV_SCHED_PERF_EN) output cycles stalled by conv_ready=0
module conv_filter_scheduler #(
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned KERNEL_SIZE  = 3,
    parameter int unsigned WEIGHT_WIDTH = 8,
    parameter int unsigned OUTPUT_WIDTH = 32,
    parameter int unsigned NUM_FILTERS  = 4,
    parameter int unsigned CONV_LATENCY = 3,
    parameter int unsigned TIMEOUT      = 8
) (
    input  logic                                                        clk,
    input  logic                                                        rst_n,
    input  logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0]               window_in,
    input  logic                                                        win_valid,
    output logic                                                        win_ready,
    input  logic [NUM_FILTERS*KERNEL_SIZE*KERNEL_SIZE*WEIGHT_WIDTH-1:0] weights,
    input  logic                                                        weights_valid,
    input  logic [NUM_FILTERS*OUTPUT_WIDTH-1:0]                         bias,
    input  logic                                                        bias_enable,
    output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0]               eng_window,
    output logic [KERNEL_SIZE*KERNEL_SIZE*WEIGHT_WIDTH-1:0]             eng_weights,
    output logic [OUTPUT_WIDTH-1:0]                                     eng_bias,
    output logic                                                        eng_bias_enable,
    output logic                                                        eng_valid,
    input  logic [OUTPUT_WIDTH-1:0]                                     eng_out,
    input  logic                                                        eng_out_valid,
    output logic [NUM_FILTERS*OUTPUT_WIDTH-1:0]                         conv_out,
    output logic                                                        conv_valid,
    input  logic                                                        conv_ready,
    output logic                                                        busy,
    output logic                                                        err
`ifdef CONV_SCHED_PERF_EN
    ,
    output logic [31:0]                                                 perf_windows,
    output logic [31:0]                                                 perf_stall
`endif
);

    localparam int unsigned KK     = KERNEL_SIZE * KERNEL_SIZE;
    localparam int unsigned WIN_W  = KK * DATA_WIDTH;
    localparam int unsigned WGT_W  = KK * WEIGHT_WIDTH;
    localparam int unsigned OW     = OUTPUT_WIDTH;
    localparam int unsigned CNT_W  = $clog2(NUM_FILTERS + 1);
    localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

    localparam logic [CNT_W-1:0]  LAST_ISSUE = CNT_W'(NUM_FILTERS - 1);
    localparam logic [CNT_W-1:0]  NF_CNT     = CNT_W'(NUM_FILTERS);
    localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(TIMEOUT - 1);

    if (NUM_FILTERS < 1 || CONV_LATENCY < 1 || TIMEOUT < 1) begin : gen_param_check
        $error("conv_filter_scheduler: NUM_FILTERS, CONV_LATENCY and TIMEOUT must be >= 1");
    end

    typedef enum logic [1:0] {StIdle, StIssue, StDrain, StOutput} state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0]        col_cnt_q, col_cnt_d;
    logic [WAIT_W-1:0]       wait_cnt_q, wait_cnt_d;
    logic [NUM_FILTERS*OW-1:0] res_q, res_d;
    logic [NUM_FILTERS*OW-1:0] conv_out_q, conv_out_d;
    logic                    err_q, err_d;
    logic [WIN_W-1:0]        eng_window_q, eng_window_d;
    logic [WGT_W-1:0]        eng_weights_q, eng_weights_d;
    logic [OW-1:0]           eng_bias_q, eng_bias_d;
    logic                    eng_bias_en_q, eng_bias_en_d;
    logic                    eng_valid_q, eng_valid_d;

    logic                    accept;
    logic                    collecting;
    logic [WGT_W-1:0]        sel_weights;
    logic [OW-1:0]           sel_bias;

    // Gated by rst_n so no window can be offered a ready while reset is held.
    assign win_ready  = rst_n && (state_q == StIdle) && weights_valid;
    assign accept     = win_valid && win_ready;
    assign collecting = (state_q == StIssue) || (state_q == StDrain);

    // Weight/bias slices of the filter currently being issued.
    always_comb begin
        sel_weights = '0;
        sel_bias    = '0;
        for (int f = 0; f < NUM_FILTERS; f++) begin
            if (issue_cnt_q == CNT_W'(f)) begin
                sel_weights = weights[f*WGT_W +: WGT_W];
                sel_bias    = bias[f*OW +: OW];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        issue_cnt_d   = issue_cnt_q;
        col_cnt_d     = col_cnt_q;
        wait_cnt_d    = wait_cnt_q;
        res_d         = res_q;
        conv_out_d    = conv_out_q;
        err_d         = err_q;
        eng_window_d  = eng_window_q;
        eng_weights_d = eng_weights_q;
        eng_bias_d    = eng_bias_q;
        eng_bias_en_d = eng_bias_en_q;
        eng_valid_d   = 1'b0;

        // Results arrive in issue order, so the collection count is the slot index.
        if (eng_out_valid) begin
            if (!collecting || (col_cnt_q == NF_CNT)) begin
                err_d = 1'b1;
            end else begin
                for (int f = 0; f < NUM_FILTERS; f++) begin
                    if (col_cnt_q == CNT_W'(f)) begin
                        res_d[f*OW +: OW] = eng_out;
                    end
                end
                col_cnt_d = col_cnt_q + 1'b1;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d       = StIssue;
                    eng_window_d  = window_in;
                    eng_bias_en_d = bias_enable;
                    res_d         = '0;
                    issue_cnt_d   = '0;
                    col_cnt_d     = '0;
                end
            end
            StIssue: begin
                eng_valid_d   = 1'b1;
                eng_weights_d = sel_weights;
                eng_bias_d    = sel_bias;
                issue_cnt_d   = issue_cnt_q + 1'b1;
                if (issue_cnt_q == LAST_ISSUE) begin
                    state_d    = StDrain;
                    wait_cnt_d = '0;
                end
            end
            StDrain: begin
                if (col_cnt_d == NF_CNT) begin
                    state_d    = StOutput;
                    conv_out_d = res_d;
                end else if (eng_out_valid) begin
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    // Give up on missing results; their slots stay zero.
                    err_d      = 1'b1;
                    state_d    = StOutput;
                    conv_out_d = res_d;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            StOutput: begin
                if (conv_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            issue_cnt_q   <= '0;
            col_cnt_q     <= '0;
            wait_cnt_q    <= '0;
            res_q         <= '0;
            conv_out_q    <= '0;
            err_q         <= 1'b0;
            eng_window_q  <= '0;
            eng_weights_q <= '0;
            eng_bias_q    <= '0;
            eng_bias_en_q <= 1'b0;
            eng_valid_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            issue_cnt_q   <= issue_cnt_d;
            col_cnt_q     <= col_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            res_q         <= res_d;
            conv_out_q    <= conv_out_d;
            err_q         <= err_d;
            eng_window_q  <= eng_window_d;
            eng_weights_q <= eng_weights_d;
            eng_bias_q    <= eng_bias_d;
            eng_bias_en_q <= eng_bias_en_d;
            eng_valid_q   <= eng_valid_d;
        end
    end

    assign eng_window      = eng_window_q;
    assign eng_weights     = eng_weights_q;
    assign eng_bias        = eng_bias_q;
    assign eng_bias_enable = eng_bias_en_q;
    assign eng_valid       = eng_valid_q;
    assign conv_out        = conv_out_q;
    assign conv_valid      = (state_q == StOutput);
    assign busy            = (state_q != StIdle);
    assign err             = err_q;

`ifdef CONV_SCHED_PERF_EN
    logic [31:0] perf_windows_q;
    logic [31:0] perf_stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_windows_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            if (accept) begin
                perf_windows_q <= perf_windows_q + 32'd1;
            end
            if ((state_q == StOutput) && !conv_ready) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_windows = perf_windows_q;
    assign perf_stall   = perf_stall_q;
`endif

endmodule
